// File: rtl/ahb_slave_mem_responder.sv
// rtl/ahb_slave_mem_responder.sv - AHB-Lite slave with word memory, wait states and two-cycle ERROR responses
module ahb_slave_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    hselx,
    input  logic                    hready,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [3:0]              hprot,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    output logic                    hreadyout,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    hresp,
    output logic                    hexokay
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int NBL  = $clog2(NB);
    localparam int IDXW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [3:0]            cnt;
    logic [IDXW-1:0]       cap_idx;
    logic [NBL-1:0]        cap_lo;
    logic                  cap_write;
    logic [2:0]            cap_size;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  can_take;
    logic                  accept;
    logic                  req_err;
    logic                  addr_oob;
    logic                  size_bad;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] align_mask;

    logic                  data_done;
    logic                  commit;
    logic [NB-1:0]         commit_mask;

    logic                  load_direct;
    logic                  load_wait;
    logic [IDXW-1:0]       rd_idx;
    logic [NB-1:0]         rd_mask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_value;

    logic                  unused_ok;

    // Lane i belongs to the transfer when it falls in the same 2^size block as the address.
    function automatic logic [NB-1:0] lane_mask(input logic [NBL-1:0] lo, input logic [2:0] size);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >> size) == (int'(lo) >> size)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    assign hexokay   = 1'b0;
    assign unused_ok = ^{hburst, hprot};

    always_comb begin
        align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
        addr_oob   = (haddr >> NBL) >= ADDR_WIDTH'(MEM_DEPTH);
        size_bad   = hsize > 3'(NBL);
        misaligned = |(haddr & align_mask);
        req_err    = addr_oob || size_bad || misaligned;
    end

    assign data_done = (state == S_DATA) && (cnt == 4'd0);
    assign can_take  = (state == S_IDLE) || (state == S_ERR2) || data_done;
    assign accept    = can_take && hselx && hready && htrans[1];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_ERR2: begin
                if (accept) state_nxt = req_err ? S_ERR1 : S_DATA;
                else        state_nxt = S_IDLE;
            end
            S_DATA: begin
                if (cnt == 4'd0) begin
                    if (accept) state_nxt = req_err ? S_ERR1 : S_DATA;
                    else        state_nxt = S_IDLE;
                end
            end
            S_ERR1: state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        unique case (state)
            S_DATA: hreadyout = (cnt == 4'd0);
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt       <= 4'd0;
            cap_idx   <= '0;
            cap_lo    <= '0;
            cap_write <= 1'b0;
            cap_size  <= 3'd0;
        end else begin
            if (accept) begin
                cap_idx   <= haddr[NBL +: IDXW];
                cap_lo    <= haddr[NBL-1:0];
                cap_write <= hwrite;
                cap_size  <= hsize;
                cnt       <= req_err ? 4'd0 : 4'(WAIT_STATES);
            end else if (state == S_DATA && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign commit      = data_done && cap_write;
    assign commit_mask = lane_mask(cap_lo, cap_size) & hwstrb;

    // Memory has no reset; an aborted data phase never reaches the commit edge.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int i = 0; i < NB; i++) begin
                if (commit_mask[i]) begin
                    mem[cap_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    assign load_direct = accept && !req_err && !hwrite && (WAIT_STATES == 0);
    assign load_wait   = (state == S_DATA) && (cnt == 4'd1) && !cap_write;
    assign rd_idx      = load_direct ? haddr[NBL +: IDXW] : cap_idx;
    assign rd_mask     = load_direct ? lane_mask(haddr[NBL-1:0], hsize) : lane_mask(cap_lo, cap_size);

    // A commit on the same edge as a load forwards the freshly written bytes.
    always_comb begin
        rd_word = mem[rd_idx];
        for (int i = 0; i < NB; i++) begin
            if (commit && (cap_idx == rd_idx) && commit_mask[i]) begin
                rd_word[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
        rd_value = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (!rd_mask[i]) begin
                rd_value[8*i +: 8] = 8'h00;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hrdata <= '0;
        end else if (load_direct || load_wait) begin
            hrdata <= rd_value;
        end else begin
            hrdata <= '0;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem_responder.sv
// tb/tb_ahb_slave_mem_responder.sv - directed and random checks of two slaves (0 and 2 wait states)
module tb_ahb_slave_mem_responder;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        sel0, sel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        ro0, ro2, rs0, rs2, ex0, ex2;
    logic [31:0] rd0, rd2;

    int total = 0;
    int bad   = 0;

    logic [7:0] mm [0:1][0:1023];

    always #5 hclk = ~hclk;

    ahb_slave_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hselx(sel0), .hready(ro0), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hwstrb(hwstrb), .hreadyout(ro0), .hrdata(rd0), .hresp(rs0), .hexokay(ex0)
    );

    ahb_slave_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
        .hclk(hclk), .hresetn(hresetn), .hselx(sel2), .hready(ro2), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hwstrb(hwstrb), .hreadyout(ro2), .hrdata(rd2), .hresp(rs2), .hexokay(ex2)
    );

    function automatic logic [31:0] o_ready(int s);
        return s != 0 ? 32'(ro2) : 32'(ro0);
    endfunction
    function automatic logic [31:0] o_resp(int s);
        return s != 0 ? 32'(rs2) : 32'(rs0);
    endfunction
    function automatic logic [31:0] o_rdata(int s);
        return s != 0 ? rd2 : rd0;
    endfunction

    function automatic bit is_err(logic [31:0] a, logic [2:0] sz);
        return (a / 4 >= 256) || (sz > 3'd2) || ((a % (32'd1 << sz)) != 0);
    endfunction

    function automatic bit lane_in(logic [31:0] a, logic [2:0] sz, int i);
        int lo;
        lo = int'(a % 4);
        return (i >= lo) && (i < lo + (1 << sz));
    endfunction

    function automatic logic [31:0] model_read(int s, logic [31:0] a, logic [2:0] sz);
        logic [31:0] r;
        r = '0;
        if (!is_err(a, sz)) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_in(a, sz, i)) r[8*i +: 8] = mm[s][int'(a & ~32'd3) + i];
            end
        end
        return r;
    endfunction

    task automatic model_write(input int s, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] wd, input logic [3:0] st);
        if (!is_err(a, sz)) begin
            for (int i = 0; i < 4; i++) begin
                if (st[i] && lane_in(a, sz, i)) mm[s][int'(a & ~32'd3) + i] = wd[8*i +: 8];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        @(negedge hclk);
    endtask

    // Single NONSEQ transfer followed by IDLE; checks every cycle of the data phase.
    task automatic xfer(input int s, input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] st, output logic [31:0] rdv);
        bit          err;
        int          ws;
        logic [31:0] exp_rd;
        ws     = (s != 0) ? 2 : 0;
        err    = is_err(a, sz);
        exp_rd = model_read(s, a, sz);
        rdv    = '0;
        haddr  = a; hwrite = w; hsize = sz; htrans = 2'b10;
        sel0   = (s == 0); sel2 = (s != 0);
        step();
        htrans = 2'b00; sel0 = 1'b0; sel2 = 1'b0; hwdata = wd; hwstrb = st;
        if (err) begin
            chk("err1_ready", o_ready(s), 32'd0);
            chk("err1_resp",  o_resp(s),  32'd1);
            chk("err1_rdata", o_rdata(s), 32'd0);
            step();
            chk("err2_ready", o_ready(s), 32'd1);
            chk("err2_resp",  o_resp(s),  32'd1);
            chk("err2_rdata", o_rdata(s), 32'd0);
        end else begin
            for (int k = 0; k <= ws; k++) begin
                chk("data_ready", o_ready(s), 32'(k == ws));
                chk("data_resp",  o_resp(s),  32'd0);
                if (k == ws) begin
                    rdv = o_rdata(s);
                    chk("data_rdata", o_rdata(s), w ? 32'd0 : exp_rd);
                end else begin
                    chk("wait_rdata", o_rdata(s), 32'd0);
                    step();
                end
            end
            if (w) model_write(s, a, sz, wd, st);
        end
        step();
        chk("idle_ready", o_ready(s), 32'd1);
        chk("idle_resp",  o_resp(s),  32'd0);
        chk("idle_rdata", o_rdata(s), 32'd0);
    endtask

    // Word write immediately followed by a word read on the zero-wait slave.
    task automatic pipe_wr_rd(input logic [31:0] aw, input logic [31:0] wd, input logic [31:0] ar,
                              output logic [31:0] rdv);
        logic [31:0] exp_rd;
        haddr = aw; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; sel0 = 1'b1; sel2 = 1'b0;
        step();
        chk("pw_ready", 32'(ro0), 32'd1);
        chk("pw_resp",  32'(rs0), 32'd0);
        hwdata = wd; hwstrb = 4'hF;
        haddr = ar; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b10;
        model_write(0, aw, 3'd2, wd, 4'hF);
        exp_rd = model_read(0, ar, 3'd2);
        step();
        chk("pr_ready", 32'(ro0), 32'd1);
        chk("pr_resp",  32'(rs0), 32'd0);
        rdv = rd0;
        chk("pr_rdata", rd0, exp_rd);
        htrans = 2'b00; sel0 = 1'b0;
        step();
        chk("pr_idle_ready", 32'(ro0), 32'd1);
        chk("pr_idle_rdata", rd0, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        hresetn = 1'b0;
        sel0 = 1'b0; sel2 = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd1; hprot = 4'h3; hwdata = '0; hwstrb = '0;
        repeat (3) @(negedge hclk);
        chk("rst_ready0", 32'(ro0), 32'd1);
        chk("rst_resp0",  32'(rs0), 32'd0);
        chk("rst_rdata0", rd0, 32'd0);
        chk("rst_exok0",  32'(ex0), 32'd0);
        chk("rst_ready2", 32'(ro2), 32'd1);
        chk("rst_rdata2", rd2, 32'd0);
        hresetn = 1'b1;
        step();

        for (int s = 0; s < 2; s++)
            for (int wi = 0; wi < 16; wi++)
                xfer(s, 32'(wi * 4), 1'b1, 3'd2, $urandom, 4'hF, r);

        pipe_wr_rd(32'h10, 32'hDEADBEEF, 32'h10, r);
        chk("t1_read_0x10", r, 32'hDEADBEEF);

        xfer(1, 32'h20, 1'b1, 3'd2, 32'hCAFEF00D, 4'hF, r);
        xfer(1, 32'h20, 1'b0, 3'd2, 32'h0, 4'h0, r);
        chk("t2_ws2_read", r, 32'hCAFEF00D);

        xfer(0, 32'h0, 1'b1, 3'd2, 32'h0BADC0DE, 4'hF, r);
        xfer(0, 32'h400, 1'b0, 3'd2, 32'h0, 4'h0, r);
        xfer(0, 32'h400, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF, r);
        xfer(0, 32'h0, 1'b0, 3'd2, 32'h0, 4'h0, r);
        chk("t3_oob_untouched", r, 32'h0BADC0DE);

        xfer(0, 32'h10, 1'b1, 3'd2, 32'h11223344, 4'hF, r);
        xfer(0, 32'h12, 1'b1, 3'd1, 32'hAAAA5555, 4'hF, r);
        xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, r);
        chk("t4_half_merge", r, 32'hAAAA3344);
        xfer(0, 32'h12, 1'b0, 3'd1, 32'h0, 4'h0, r);
        chk("t4_half_read", r, 32'hAAAA0000);
        xfer(0, 32'h11, 1'b0, 3'd1, 32'h0, 4'h0, r);
        xfer(0, 32'h11, 1'b1, 3'd1, 32'h77777777, 4'hF, r);
        xfer(0, 32'h10, 1'b0, 3'd3, 32'h0, 4'h0, r);
        xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, r);
        chk("t4_misaligned_untouched", r, 32'hAAAA3344);

        pipe_wr_rd(32'h30, 32'h12345678, 32'h30, r);
        chk("t5_forward", r, 32'h12345678);

        haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; sel2 = 1'b1;
        step();
        htrans = 2'b00; sel2 = 1'b0; hwdata = 32'h55667788; hwstrb = 4'hF;
        chk("t6_wait_ready", 32'(ro2), 32'd0);
        hresetn = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(ro2), 32'd1);
        chk("t6_rst_resp",  32'(rs2), 32'd0);
        chk("t6_rst_rdata", rd2, 32'd0);
        step();
        hresetn = 1'b1;
        step();
        xfer(1, 32'h20, 1'b0, 3'd2, 32'h0, 4'h0, r);
        chk("t6_old_word", r, 32'hCAFEF00D);

        for (int n = 0; n < 80; n++) begin
            int          s;
            logic [2:0]  sz;
            logic [31:0] a;
            s  = int'($urandom % 2);
            sz = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
            a  = ($urandom % 10 == 0) ? (32'h400 + ($urandom % 64)) : ($urandom % 64);
            xfer(s, a, 1'($urandom), sz, $urandom, 4'($urandom), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem_responder.md
Name: ahb_slave_mem_responder

Overview:
AHB-Lite slave with a word-addressed internal memory, programmable wait states and two-cycle ERROR responses. Sits directly downstream of the slave-side decoder/mux, on the same signals the slave assertion interface monitors. It is the response-producing endpoint for hreadyout, hrdata and hresp in the slave agent environment.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width (bytes per word NB = DATA_WIDTH/8)
MEM_DEPTH, 256, number of DATA_WIDTH words
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15)

Ports:
hclk  in  1  clock, rising edge
hresetn  in  1  asynchronous active-low reset
hselx  in  1  slave select
hready  in  1  bus-level ready (mux output)
haddr  in  ADDR_WIDTH  byte address
htrans  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
hwrite  in  1  1=write
hsize  in  3  transfer size log2(bytes)
hburst  in  3  accepted, ignored
hprot  in  4  accepted, ignored
hwdata  in  DATA_WIDTH  write data (data phase)
hwstrb  in  NB  write byte strobes (data phase)
hreadyout  out  1  slave ready
hrdata  out  DATA_WIDTH  read data
hresp  out  1  0=OKAY 1=ERROR
hexokay  out  1  exclusive okay, constant 0

Behaviour:
- Reset (async, hresetn=0): state IDLE, hreadyout=1, hresp=0, hrdata=0, hexokay=0, counter=0, any pending write discarded. Memory contents are not reset and are kept across reset.
- Accept: transfer is accepted on a rising edge when hselx && hready && htrans[1]. At that edge, capture haddr, hwrite and hsize.
- IDLE/BUSY, or not selected: no state change. The slave stays ready with OKAY.
- Error check at accept. ERROR if any of:
  - word index haddr/NB >= MEM_DEPTH
  - hsize > log2(NB)
  - haddr not aligned to 2^hsize
- States:
  - IDLE: hreadyout=1, hresp=0.
  - DATA: loaded with cnt=WAIT_STATES. hreadyout=(cnt==0), hresp=0. cnt decrements each cycle while nonzero. The phase completes on the edge where cnt==0.
  - ERR1: hreadyout=0, hresp=1. Always followed by ERR2.
  - ERR2: hreadyout=1, hresp=1, then IDLE.
- Transitions on the completing edge of DATA, or from ERR2 or IDLE: a new accept goes to DATA or ERR1, otherwise to IDLE. Back-to-back pipelined transfers therefore incur no idle cycle.
- Write commit: on the completing edge of DATA only. Byte i is written iff hwstrb[i] && lane i lies within the captured size/address. ERROR writes never modify memory.
- Read data: registered into hrdata on the edge entering the ready cycle of DATA. That edge is the accept edge when WAIT_STATES=0, else the edge where cnt goes 1->0.
  - Lanes outside the transfer read 0.
  - hrdata returns to 0 on the edge after the completing cycle, and on ERROR paths.
- Forwarding: if a write commit and a read load occur on the same edge to the same word, hrdata carries the post-write (merged) bytes.
- Transfers presented during ERR2 are accepted normally.
- No 1KB burst-boundary checking.
- Reset mid-DATA: abort immediately. Memory is unchanged for an uncommitted write.

Test Plan:
- WAIT_STATES=0: NONSEQ write 0x0000_0010 = 0xDEADBEEF, hwstrb=F, then read same address -> read data phase hreadyout=1, hrdata=0xDEADBEEF, hresp=0; zero idle cycles between phases.
- WAIT_STATES=2: single read of 0x20 -> hreadyout low 2 cycles then high, hrdata valid only in the ready cycle, hresp=0 throughout.
- Read at haddr=0x400 (index 256 = MEM_DEPTH) -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), then IDLE; a write to the same address leaves memory untouched.
- Halfword write 0xAAAA at 0x12 (hsize=1, hwstrb=F) over existing 0x11223344 at 0x10 -> word reads 0xAAAA3344; a misaligned halfword at 0x11 -> ERROR.
- Back-to-back write 0x30=0x12345678 followed immediately by read 0x30, WAIT_STATES=0 -> read returns 0x12345678 via forwarding.
- Assert hresetn=0 mid-DATA of a wait-state write -> outputs reset immediately (hreadyout=1, hresp=0, hrdata=0); subsequent read shows the old word value.
